// File: rtl/pueo_trig_pkg.sv
// Shared constants, width helpers and the holdoff state type for the beam trigger array.
package pueo_trig_pkg;

    localparam int DEF_NBEAMS  = 2;
    localparam int DEF_NSAMP   = 2;
    localparam int DEF_DW      = 17;
    localparam int DEF_HOLDOFF = 0;
    localparam int DEF_SCW     = 16;

    // Sum/threshold width: wide enough that NSAMP full-scale samples never overflow.
    function automatic int calc_tw(input int dw, input int nsamp);
        return dw + $clog2(nsamp);
    endfunction

    // Beam address width, kept at least one bit so a single-beam build still has ports.
    function automatic int calc_aw(input int nbeams);
        return (nbeams > 1) ? $clog2(nbeams) : 1;
    endfunction

    typedef enum logic {
        HS_IDLE = 1'b0,
        HS_HOLD = 1'b1
    } hold_state_t;

endpackage

// File: rtl/pueo_beam_trig_chan.sv
// One beam: sample capture, sum, strict threshold compare against an active threshold
// fed from a shadow register, mask, optional holdoff dead-time and a saturating scaler.
module pueo_beam_trig_chan
    import pueo_trig_pkg::*;
#(
    parameter int NSAMP   = DEF_NSAMP,
    parameter int DW      = DEF_DW,
    parameter int HOLDOFF = DEF_HOLDOFF,
    parameter int SCW     = DEF_SCW,
    parameter int TW      = calc_tw(DW, NSAMP)
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [NSAMP*DW-1:0] samp_i,
    input  logic [TW-1:0]       thresh_i,
    input  logic                thresh_wr_i,
    input  logic                update_i,
    input  logic                mask_i,
    input  logic                scaler_clr_i,
    output logic                trigger_o,
    output logic [SCW-1:0]      scaler_o
);

    localparam int HCW = (HOLDOFF > 0) ? $clog2(HOLDOFF + 1) : 1;

    logic [DW-1:0]  samp_q [NSAMP];
    logic [DW-1:0]  samp_d [NSAMP];
    logic [TW-1:0]  sum_q, sum_d;
    logic [TW-1:0]  shadow_q, shadow_d;
    logic [TW-1:0]  active_q, active_d;
    logic           mask_q, mask_d;
    logic           hit;
    hold_state_t    state_q, state_d;
    logic [HCW-1:0] cnt_q, cnt_d;
    logic           trig_q, trig_d;
    logic [SCW-1:0] scaler_q, scaler_d;

    // Stage 1: unpack this beam's samples for capture.
    always_comb begin
        for (int s = 0; s < NSAMP; s++) begin
            samp_d[s] = samp_i[s*DW +: DW];
        end
    end

    // Stage 2: unsigned sum at full width so it can never wrap.
    always_comb begin
        sum_d = '0;
        for (int s = 0; s < NSAMP; s++) begin
            sum_d = sum_d + TW'(samp_q[s]);
        end
    end

    // Threshold and mask registers; update copies the shadow value seen before any same-cycle write.
    always_comb begin
        shadow_d = shadow_q;
        active_d = active_q;
        mask_d   = mask_i;
        if (update_i) begin
            active_d = shadow_q;
        end
        if (thresh_wr_i) begin
            shadow_d = thresh_i;
        end
    end

    // Strict compare: an all-ones threshold can never be exceeded.
    assign hit = (sum_q > active_q) && !mask_q;

    // Stage 3: level trigger, or one-cycle pulse followed by HOLDOFF dead clocks.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        trig_d  = 1'b0;
        if (HOLDOFF == 0) begin
            trig_d = hit;
        end else begin
            case (state_q)
                HS_IDLE: begin
                    if (hit) begin
                        trig_d  = 1'b1;
                        cnt_d   = HCW'(HOLDOFF);
                        state_d = HS_HOLD;
                    end
                end
                HS_HOLD: begin
                    cnt_d = cnt_q - 1'b1;
                    if (cnt_q == HCW'(1)) begin
                        state_d = HS_IDLE;
                    end
                end
                default: state_d = HS_IDLE;
            endcase
        end
    end

    // Scaler counts cycles with trigger high, saturating; clear has priority.
    always_comb begin
        scaler_d = scaler_q;
        if (scaler_clr_i) begin
            scaler_d = '0;
        end else if (trig_q && (scaler_q != '1)) begin
            scaler_d = scaler_q + 1'b1;
        end
    end

    // All channel state; reset discards anything in flight and parks thresholds/mask safe.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            samp_q   <= '{default: '0};
            sum_q    <= '0;
            shadow_q <= '1;
            active_q <= '1;
            mask_q   <= 1'b1;
            state_q  <= HS_IDLE;
            cnt_q    <= '0;
            trig_q   <= 1'b0;
            scaler_q <= '0;
        end else begin
            samp_q   <= samp_d;
            sum_q    <= sum_d;
            shadow_q <= shadow_d;
            active_q <= active_d;
            mask_q   <= mask_d;
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            trig_q   <= trig_d;
            scaler_q <= scaler_d;
        end
    end

    assign trigger_o = trig_q;
    assign scaler_o  = scaler_q;

endmodule

// File: rtl/pueo_beam_trigger_array.sv
// Array of independent beam trigger channels with addressed threshold writes,
// a global threshold update strobe and a registered scaler readout mux.
module pueo_beam_trigger_array
    import pueo_trig_pkg::*;
#(
    parameter int NBEAMS  = DEF_NBEAMS,
    parameter int NSAMP   = DEF_NSAMP,
    parameter int DW      = DEF_DW,
    parameter int HOLDOFF = DEF_HOLDOFF,
    parameter int SCW     = DEF_SCW,
    localparam int TW     = calc_tw(DW, NSAMP),
    localparam int AW     = calc_aw(NBEAMS)
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic [NBEAMS*NSAMP*DW-1:0] beam_i,
    input  logic [TW-1:0]              thresh_i,
    input  logic [AW-1:0]              thresh_addr_i,
    input  logic                       thresh_wr_i,
    input  logic                       update_i,
    input  logic [NBEAMS-1:0]          mask_i,
    input  logic [AW-1:0]              scaler_addr_i,
    input  logic                       scaler_clr_i,
    output logic [NBEAMS-1:0]          trigger_o,
    output logic [SCW-1:0]             scaler_o
);

    logic [SCW-1:0] scaler_w [NBEAMS];
    logic [SCW-1:0] scaler_rd_q, scaler_rd_d;

    // One channel per beam; an out-of-range write address matches no channel.
    for (genvar gi = 0; gi < NBEAMS; gi++) begin : g_beam
        pueo_beam_trig_chan #(
            .NSAMP   (NSAMP),
            .DW      (DW),
            .HOLDOFF (HOLDOFF),
            .SCW     (SCW),
            .TW      (TW)
        ) u_chan (
            .clk_i        (clk_i),
            .rst_i        (rst_i),
            .samp_i       (beam_i[gi*NSAMP*DW +: NSAMP*DW]),
            .thresh_i     (thresh_i),
            .thresh_wr_i  (thresh_wr_i && (int'(thresh_addr_i) == gi)),
            .update_i     (update_i),
            .mask_i       (mask_i[gi]),
            .scaler_clr_i (scaler_clr_i),
            .trigger_o    (trigger_o[gi]),
            .scaler_o     (scaler_w[gi])
        );
    end

    // Readout mux; addresses with no beam read as zero.
    always_comb begin
        scaler_rd_d = '0;
        for (int b = 0; b < NBEAMS; b++) begin
            if (int'(scaler_addr_i) == b) begin
                scaler_rd_d = scaler_w[b];
            end
        end
    end

    // Registered scaler output.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            scaler_rd_q <= '0;
        end else begin
            scaler_rd_q <= scaler_rd_d;
        end
    end

    assign scaler_o = scaler_rd_q;

endmodule

// File: tb/tb_pueo_beam_trigger_array.sv
// Bench for pueo_beam_trigger_array: a default instance and a 4-bit-scaler twin share one
// stimulus stream checked every cycle against a history-based reference model; a wide
// instance (8 beams, 4 samples, holdoff 4) covers dead-time and reset-in-hold behaviour.
module tb_pueo_beam_trigger_array;

    localparam int NB = 2;
    localparam int NS = 2;
    localparam int DW = 17;
    localparam int TW = 18;

    localparam int NB_B = 8;
    localparam int NS_B = 4;
    localparam int TW_B = 19;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // shared stimulus of the default instance and the 4-bit scaler instance
    logic                  rst_a;
    logic [NB*NS*DW-1:0]   beam_a;
    logic [TW-1:0]         thresh_a;
    logic [0:0]            taddr_a, saddr_a;
    logic                  twr_a, upd_a, sclr_a;
    logic [NB-1:0]         mask_a, trig_a, trig_c;
    logic [15:0]           scal_a;
    logic [3:0]            scal_c;

    // wide holdoff instance
    logic                    rst_b;
    logic [NB_B*NS_B*DW-1:0] beam_b;
    logic [TW_B-1:0]         thresh_b;
    logic [2:0]              taddr_b, saddr_b;
    logic                    twr_b, upd_b, sclr_b;
    logic [NB_B-1:0]         mask_b, trig_b;
    logic [3:0]              scal_b;

    pueo_beam_trigger_array dut_a (
        .clk_i(clk), .rst_i(rst_a), .beam_i(beam_a), .thresh_i(thresh_a),
        .thresh_addr_i(taddr_a), .thresh_wr_i(twr_a), .update_i(upd_a), .mask_i(mask_a),
        .scaler_addr_i(saddr_a), .scaler_clr_i(sclr_a), .trigger_o(trig_a), .scaler_o(scal_a)
    );

    pueo_beam_trigger_array #(.SCW(4)) dut_c (
        .clk_i(clk), .rst_i(rst_a), .beam_i(beam_a), .thresh_i(thresh_a),
        .thresh_addr_i(taddr_a), .thresh_wr_i(twr_a), .update_i(upd_a), .mask_i(mask_a),
        .scaler_addr_i(saddr_a), .scaler_clr_i(sclr_a), .trigger_o(trig_c), .scaler_o(scal_c)
    );

    pueo_beam_trigger_array #(.NBEAMS(8), .NSAMP(4), .HOLDOFF(4), .SCW(4)) dut_b (
        .clk_i(clk), .rst_i(rst_b), .beam_i(beam_b), .thresh_i(thresh_b),
        .thresh_addr_i(taddr_b), .thresh_wr_i(twr_b), .update_i(upd_b), .mask_i(mask_b),
        .scaler_addr_i(saddr_b), .scaler_clr_i(sclr_b), .trigger_o(trig_b), .scaler_o(scal_b)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d required %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model for the shared stream ----------------
    // Index i holds what the edge following record i samples. The output seen after
    // edge n derives from the sum sampled at edge n-2 and from the threshold/mask in
    // force once edge n-1 has passed.
    int              cyc = 0;
    int              valid_from = 0;
    int unsigned     sum_hist  [8][NB];
    logic [TW-1:0]   act_hist  [8][NB];
    logic [NB-1:0]   mask_hist [8];
    logic [TW-1:0]   shadow_m  [NB];
    logic [TW-1:0]   active_m  [NB];
    int unsigned     scal_m    [NB];
    int unsigned     scal_mc   [NB];
    logic [NB-1:0]   trig_prev;

    task automatic model_reset();
        for (int b = 0; b < NB; b++) begin
            shadow_m[b] = '1;
            active_m[b] = '1;
            scal_m[b]   = 0;
            scal_mc[b]  = 0;
        end
        trig_prev = '0;
    endtask

    task automatic set_all_a(input int unsigned v);
        for (int i = 0; i < NB*NS; i++) beam_a[i*DW +: DW] = DW'(v);
    endtask

    task automatic cycle_a();
        int          idx, n;
        int unsigned s, exp_sa, exp_sc;
        logic [NB-1:0] exp_t;
        idx = cyc % 8;
        for (int b = 0; b < NB; b++) begin
            s = 0;
            for (int k = 0; k < NS; k++) s += beam_a[(b*NS+k)*DW +: DW];
            sum_hist[idx][b] = s;
        end
        if (upd_a) active_m = shadow_m;
        if (twr_a && (int'(taddr_a) < NB)) shadow_m[taddr_a] = thresh_a;
        act_hist[idx]  = active_m;
        mask_hist[idx] = mask_a;
        exp_sa = (int'(saddr_a) < NB) ? scal_m[saddr_a]  : 0;
        exp_sc = (int'(saddr_a) < NB) ? scal_mc[saddr_a] : 0;
        for (int b = 0; b < NB; b++) begin
            if (sclr_a) begin
                scal_m[b] = 0; scal_mc[b] = 0;
            end else if (trig_prev[b]) begin
                if (scal_m[b] < 65535) scal_m[b]++;
                if (scal_mc[b] < 15) scal_mc[b]++;
            end
        end
        @(posedge clk); #1;
        cyc++;
        twr_a = 1'b0; upd_a = 1'b0; sclr_a = 1'b0;
        n = cyc;
        exp_t = '0;
        if (n - 3 >= valid_from) begin
            for (int b = 0; b < NB; b++)
                exp_t[b] = !mask_hist[(n-2)%8][b] && (sum_hist[(n-3)%8][b] > act_hist[(n-2)%8][b]);
        end
        chk("trig_a", 64'(trig_a), 64'(exp_t));
        chk("trig_c", 64'(trig_c), 64'(exp_t));
        chk("scaler_a", 64'(scal_a), 64'(exp_sa));
        chk("scaler_c", 64'(scal_c), 64'(exp_sc));
        trig_prev = exp_t;
    endtask

    task automatic reset_a();
        rst_a = 1'b1;
        set_all_a(0);
        twr_a = 1'b0; upd_a = 1'b0; sclr_a = 1'b0; mask_a = '0; saddr_a = '0;
        #1;
        chk("rst_async_trig_a", 64'(trig_a), 64'd0);
        chk("rst_async_scal_a", 64'(scal_a), 64'd0);
        repeat (2) begin @(posedge clk); #1; cyc++; end
        chk("rst_hold_trig_c", 64'(trig_c), 64'd0);
        chk("rst_hold_scal_c", 64'(scal_c), 64'd0);
        rst_a = 1'b0;
        valid_from = cyc;
        model_reset();
    endtask

    task automatic program_a(input int b, input logic [TW-1:0] thr);
        thresh_a = thr; taddr_a = 1'(b); twr_a = 1'b1;
        cycle_a();
    endtask

    // ---------------- wide instance helpers ----------------
    task automatic tick_b();
        @(posedge clk); #1;
        twr_b = 1'b0; upd_b = 1'b0; sclr_b = 1'b0;
    endtask

    task automatic set_beam_b(input int b, input int unsigned v);
        for (int k = 0; k < NS_B; k++) beam_b[(b*NS_B+k)*DW +: DW] = DW'(v);
    endtask

    task automatic set_all_b(input int unsigned v);
        for (int b = 0; b < NB_B; b++) set_beam_b(b, v);
    endtask

    task automatic program_b(input int b, input logic [TW_B-1:0] thr);
        thresh_b = thr; taddr_b = 3'(b); twr_b = 1'b1;
        tick_b();
        upd_b = 1'b1;
        tick_b();
    endtask

    typedef struct {
        logic [TW-1:0] thr0;
        logic [TW-1:0] thr1;
        int unsigned   val;
        logic [1:0]    exp;
    } vec_t;

    vec_t vtab[10];

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int first0, first1, first_b, last_b, cnt_b, any_other, found;

        // {thr0, thr1, per-sample value, expected trigger[1:0]}; sums are 2*value
        vtab[0] = '{18'd10,      18'd20,      0,      2'b00};
        vtab[1] = '{18'd10,      18'd20,      5,      2'b00};
        vtab[2] = '{18'd10,      18'd20,      6,      2'b01};
        vtab[3] = '{18'd10,      18'd20,      10,     2'b01};
        vtab[4] = '{18'd10,      18'd20,      11,     2'b11};
        vtab[5] = '{18'd10,      18'd20,      30,     2'b11};
        vtab[6] = '{18'h3FFFF,   18'd0,       65535,  2'b10};
        vtab[7] = '{18'h3FFFF,   18'd0,       65536,  2'b10};
        vtab[8] = '{18'h3FFFF,   18'd0,       0,      2'b00};
        vtab[9] = '{18'h3FFFD,   18'h3FFFE,   131071, 2'b01};

        rst_a = 1'b1; beam_a = '0; thresh_a = '0; taddr_a = '0; saddr_a = '0;
        twr_a = 1'b0; upd_a = 1'b0; sclr_a = 1'b0; mask_a = '0;
        rst_b = 1'b1; beam_b = '0; thresh_b = '0; taddr_b = '0; saddr_b = '0;
        twr_b = 1'b0; upd_b = 1'b0; sclr_b = 1'b0; mask_b = '0;
        model_reset();

        // ---- streamed ramp with thresholds 10 / 20 ----
        reset_a();
        program_a(0, 18'd10);
        program_a(1, 18'd20);
        upd_a = 1'b1; cycle_a();
        repeat (3) cycle_a();
        first0 = -1; first1 = -1;
        for (int k = 0; k < 34; k++) begin
            set_all_a((k <= 30) ? k : 30);
            cycle_a();
            if (first0 < 0 && trig_a[0]) first0 = k - 2;
            if (first1 < 0 && trig_a[1]) first1 = k - 2;
        end
        $display("ramp: beam0 first at input %0d, beam1 first at input %0d", first0, first1);
        chk("ramp_first_beam0", 64'(first0), 64'd6);
        chk("ramp_first_beam1", 64'(first1), 64'd11);

        // ---- threshold table, including the all-ones and zero extremes ----
        for (int i = 0; i < 10; i++) begin
            program_a(0, vtab[i].thr0);
            program_a(1, vtab[i].thr1);
            upd_a = 1'b1; cycle_a();
            set_all_a(vtab[i].val);
            repeat (4) cycle_a();
            $display("vec %0d: thr0=%0h thr1=%0h val=%0d trig=%b want=%b",
                     i, vtab[i].thr0, vtab[i].thr1, vtab[i].val, trig_a, vtab[i].exp);
            chk("table_trig", 64'(trig_a), 64'(vtab[i].exp));
        end

        // ---- shadow vs active threshold timing ----
        program_a(0, 18'h3FFFF);
        program_a(1, 18'h3FFFF);
        upd_a = 1'b1; cycle_a();
        set_all_a(10);
        program_a(0, 18'd5);
        repeat (4) cycle_a();
        chk("shadow_only_no_trig", 64'(trig_a[0]), 64'd0);
        upd_a = 1'b1; cycle_a();
        chk("update_not_yet", 64'(trig_a[0]), 64'd0);
        cycle_a();
        chk("update_effective", 64'(trig_a[0]), 64'd1);
        thresh_a = 18'h3FFFF; taddr_a = 1'b0; twr_a = 1'b1; upd_a = 1'b1;
        cycle_a();
        repeat (4) cycle_a();
        chk("wr_upd_same_cycle_keeps_old", 64'(trig_a[0]), 64'd1);
        upd_a = 1'b1; cycle_a();
        repeat (2) cycle_a();
        chk("later_update_applies", 64'(trig_a[0]), 64'd0);
        $display("shadow/active sequence done");

        // ---- scaler saturation and clear-over-increment ----
        reset_a();
        saddr_a = 1'b0;
        program_a(0, 18'd0);
        program_a(1, 18'd0);
        upd_a = 1'b1; cycle_a();
        set_all_a(1);
        repeat (24) cycle_a();
        chk("scaler_c_saturated", 64'(scal_c), 64'd15);
        sclr_a = 1'b1; cycle_a();
        cycle_a();
        chk("scaler_c_clear_wins", 64'(scal_c), 64'd0);
        chk("scaler_a_clear_wins", 64'(scal_a), 64'd0);
        $display("scaler saturation/clear sequence done");

        // ---- randomized stream with a mid-stream reset ----
        for (int i = 0; i < 300; i++) begin
            if (i == 150) reset_a();
            for (int k = 0; k < NB*NS; k++) beam_a[k*DW +: DW] = DW'($urandom_range(0, 60));
            if ($urandom_range(0, 3) == 0) begin
                twr_a = 1'b1; taddr_a = 1'($urandom_range(0, 1));
                thresh_a = TW'($urandom_range(0, 150));
            end
            if ($urandom_range(0, 7) == 0) upd_a = 1'b1;
            if ($urandom_range(0, 15) == 0) mask_a = NB'($urandom_range(0, 3));
            if ($urandom_range(0, 31) == 0) sclr_a = 1'b1;
            saddr_a = 1'($urandom_range(0, 1));
            cycle_a();
        end
        $display("random stream done");

        // ---- wide instance: holdoff pulses ----
        tick_b(); tick_b();
        chk("b_reset_trig", 64'(trig_b), 64'd0);
        chk("b_reset_scal", 64'(scal_b), 64'd0);
        rst_b = 1'b0;
        program_b(0, 19'd100);
        mask_b = '0; saddr_b = 3'd0;
        tick_b(); tick_b(); tick_b();
        first_b = -1; last_b = -1; cnt_b = 0; any_other = 0;
        for (int k = 0; k < 60; k++) begin
            set_beam_b(0, (k < 50) ? 50 : 0);
            tick_b();
            if (trig_b[7:1] != '0) any_other = 1;
            if (trig_b[0]) begin
                if (first_b < 0) first_b = k;
                else chk("hold_gap", 64'(k - last_b), 64'd5);
                last_b = k;
                cnt_b++;
            end
        end
        $display("holdoff: first pulse at %0d, %0d pulses, scaler=%0d", first_b, cnt_b, scal_b);
        chk("hold_first_latency", 64'(first_b), 64'd2);
        chk("hold_pulse_count", 64'(cnt_b), 64'd10);
        chk("hold_scaler", 64'(scal_b), 64'd10);
        chk("hold_other_beams_quiet", 64'(any_other), 64'd0);

        // ---- wide instance: asynchronous reset while in HOLD ----
        set_beam_b(0, 50);
        found = 0;
        for (int k = 0; k < 12 && found == 0; k++) begin
            tick_b();
            if (trig_b[0]) found = 1;
        end
        chk("hold_reentry_seen", 64'(found), 64'd1);
        #1 rst_b = 1'b1;
        #1;
        chk("rst_in_hold_trig", 64'(trig_b), 64'd0);
        chk("rst_in_hold_scal", 64'(scal_b), 64'd0);
        tick_b();
        rst_b = 1'b0;
        set_all_b(131071);
        any_other = 0;
        for (int k = 0; k < 20; k++) begin
            tick_b();
            if (trig_b != '0) any_other = 1;
        end
        chk("post_reset_thresh_all_ones", 64'(any_other), 64'd0);
        chk("post_reset_scal", 64'(scal_b), 64'd0);
        set_all_b(0);
        set_beam_b(0, 50);
        program_b(0, 19'd100);
        found = 0;
        for (int k = 0; k < 12 && found == 0; k++) begin
            tick_b();
            if (trig_b[0]) found = 1;
        end
        chk("reprogram_triggers", 64'(found), 64'd1);
        $display("reset-in-hold sequence done");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pueo_beam_trigger_array.md
PUEO_BEAM_TRIGGER_ARRAY -- requirements
Module: pueo_beam_trigger_array

Interface
REQ-001 Parameter NBEAMS, default 2: number of independent beams.
REQ-002 Parameter NSAMP, default 2: inputs summed per beam per clock.
REQ-003 Parameter DW, default 17: unsigned width of each beam input.
REQ-004 Parameter HOLDOFF, default 0: per-beam dead-time in clocks after a trigger; 0 disables.
REQ-005 Parameter SCW, default 16: scaler counter width.
REQ-006 Derived TW = DW + clog2(NSAMP): sum and threshold width (18 at defaults).
REQ-007 clk_i  in  1  single clock; all logic on rising edge.
REQ-008 rst_i  in  1  asynchronous, active-high reset.
REQ-009 beam_i  in  NBEAMS*NSAMP*DW  packed inputs; beam b, sample s at slice (b*NSAMP+s)*DW.
REQ-010 thresh_i  in  TW  threshold write data.
REQ-011 thresh_addr_i  in  clog2(NBEAMS)  beam selected for threshold write.
REQ-012 thresh_wr_i  in  1  write thresh_i to shadow threshold of beam thresh_addr_i.
REQ-013 update_i  in  1  copy all shadow thresholds to active thresholds.
REQ-014 mask_i  in  NBEAMS  per-beam trigger mask; 1 = beam suppressed.
REQ-015 scaler_addr_i  in  clog2(NBEAMS)  beam selected for scaler readout.
REQ-016 scaler_clr_i  in  1  clear all scalers.
REQ-017 trigger_o  out  NBEAMS  per-beam trigger.
REQ-018 scaler_o  out  SCW  trigger count of selected beam.

Function
REQ-019 Pipeline: stage 1 registers beam_i; stage 2 registers per-beam unsigned sum (TW bits, no overflow); stage 3 registers compare result.
REQ-020 Raw hit for beam b SHALL be sum > active threshold (strict); threshold 2^TW-1 never hits; threshold 0 hits on any nonzero sum.
REQ-021 trigger_o[b] SHALL assert exactly 3 clocks after the beam_i sample producing the hit (input at edge N -> output after edge N+3).
REQ-022 Threshold writes SHALL affect only the shadow register; active threshold changes only on update_i, all beams simultaneously, taking effect for comparisons registered the cycle after update_i is sampled.
REQ-023 thresh_wr_i and update_i in same cycle: shadow takes new data, active takes pre-write shadow value; new value needs a later update_i.
REQ-024 thresh_addr_i >= NBEAMS with thresh_wr_i: write ignored.
REQ-025 mask_i SHALL be registered and applied at stage 3; masked beam outputs 0, does not start holdoff, does not count.
REQ-026 HOLDOFF=0: trigger_o[b] = registered raw hit every cycle (level).
REQ-027 HOLDOFF>0: per-beam state IDLE/HOLD; IDLE + hit -> trigger_o[b]=1 one cycle, load counter HOLDOFF, go HOLD; HOLD suppresses output, decrements, returns IDLE when counter reaches 0; next trigger possible HOLDOFF+1 clocks after previous.
REQ-028 Scaler b SHALL increment on each clock trigger_o[b]=1, saturating at 2^SCW-1.
REQ-029 scaler_clr_i SHALL zero all scalers next clock; clear wins over simultaneous increment.
REQ-030 scaler_o SHALL be registered, showing scaler[scaler_addr_i] one clock after address sampled; out-of-range address reads 0.

Reset
REQ-031 rst_i SHALL asynchronously set: pipeline registers 0, shadow and active thresholds all-ones, mask register all-ones, holdoff state IDLE with counter 0, scalers 0, trigger_o 0, scaler_o 0.
REQ-032 Reset mid-holdoff or mid-pipeline SHALL discard in-flight hits; no trigger_o within 3 clocks after rst_i deasserts.

Structure
REQ-033 Package pueo_trig_pkg SHALL hold default parameter constants, TW derivation function, and holdoff state enum.
REQ-034 One sub-module pueo_beam_trig_chan SHALL implement one beam (sum, compare, mask, holdoff, scaler), instantiated NBEAMS times by generate.

Verification
REQ-035 Defaults; thresh 10 -> beam0, 20 -> beam1, update; unmasked; ramp all inputs 0..30 -> beam0 triggers from input 6 (sum 12), beam1 from 11 (sum 22), 3-clock latency.
REQ-036 Thresh beam0 = 0x3FFFF, beam1 = 0; inputs 65535 then 65536 -> beam0 never triggers (sum 131072 < 0x3FFFF); beam1 triggers only for nonzero inputs.
REQ-037 Write shadow thresh 5 without update, sum 20 -> no trigger; update_i -> trigger begins next compare cycle; thresh_wr+update same cycle verifies REQ-023.
REQ-038 HOLDOFF=4, constant hit -> trigger_o[0] pulses every 5 clocks; scaler after 50 clocks of hit = 10.
REQ-039 SCW=4, continuous hit with HOLDOFF=0 -> scaler saturates at 15; scaler_clr_i with simultaneous trigger -> 0.
REQ-040 NBEAMS=8, NSAMP=4; assert rst_i during HOLD -> all outputs 0 immediately, thresholds all-ones, no trigger after release until reprogrammed.
